cbus_rr_arbiter: RTL
====================

# cbus_rr_arbiter

Round-robin arbiter that shares one CBus master port between `NUM_INPUTS` requesters (I-fetch, D-cache, page-table walker, …) and sits directly in front of the MMU/memory CBus path. Grants are fair (rotating priority) and held for the whole transaction. A per-requester lock keeps the grant across up to `LOCK_MAX` back-to-back transactions, bounded in time by `HOLD_TIMEOUT`, so atomic read-modify-write sequences are not interleaved.

## Interface
- `NUM_INPUTS`, 2: number of requesters, ≥1.
- `LOCK_MAX`, 4: maximum consecutive transactions one owner may hold while locked, ≥1.
- `HOLD_TIMEOUT`, 16: maximum idle cycles in HOLD before the lock is forcibly released, ≥1.
- `IDXW` (localparam): max(1, $clog2(NUM_INPUTS)).

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `ireqs`  in  cbus_req_t[NUM_INPUTS]  requester CBus requests.
- `ilock`  in  [NUM_INPUTS]  per-requester lock request.
- `iresps`  out  cbus_resp_t[NUM_INPUTS]  per-requester responses.
- `oreq`  out  cbus_req_t  shared downstream request.
- `oresp`  in  cbus_resp_t  shared downstream response.
- `grant_valid`  out  1  high in BUSY.
- `grant_idx`  out  IDXW  current owner index, meaningful in BUSY and HOLD.

## Operation
- State machine: IDLE, BUSY, HOLD. Registers: `state`, `owner`, `ptr` (next-priority index), `lock_cnt`, `hold_cnt`.
- IDLE:
  - `oreq='0`, `iresps='0`.
  - Select the first `i` with `ireqs[i].valid`, scanning `ptr, ptr+1, …` mod NUM_INPUTS.
  - If one is found: `owner<=i`, go to BUSY. Otherwise stay in IDLE.
- BUSY:
  - `oreq=ireqs[owner]`; `iresps[owner]=oresp`; all other `iresps='0`.
  - On `oresp.ready && oresp.last`: `ptr<=(owner+1) mod NUM_INPUTS`.
  - If `ilock[owner]` (sampled on that beat) and `lock_cnt<LOCK_MAX-1`: `lock_cnt++`, `hold_cnt<=0`, go to HOLD.
  - Otherwise `lock_cnt<=0` and go to IDLE.
- HOLD:
  - `oreq='0`, `iresps='0`, `owner` unchanged.
  - Checks in priority order:
    1. `ireqs[owner].valid`: go to BUSY.
    2. `!ilock[owner]`: go to IDLE and clear `lock_cnt`.
    3. `hold_cnt==HOLD_TIMEOUT-1`: go to IDLE and clear `lock_cnt`.
    4. Otherwise `hold_cnt++`.
  - Other requesters are ignored while in HOLD.
- Requester contract:
  - `valid` and the request fields stay stable from assertion until the last beat.
  - Dropping `valid` in BUSY before `last` is illegal; the bench asserts on it.
- `ptr` only advances on completion, so a locked sequence does not consume extra priority turns.
- NUM_INPUTS=1 degenerates to pass-through with a one-cycle issue delay; `ptr` stays 0.
- Counter widths: `lock_cnt` is $clog2(LOCK_MAX)+1 bits and `hold_cnt` is $clog2(HOLD_TIMEOUT)+1 bits. Neither counter wraps.

## Timing
- Reset (asynchronous assert, synchronous release):
  - `state=IDLE`, `owner=0`, `ptr=0`, `lock_cnt=0`, `hold_cnt=0`.
  - Outputs: `oreq='0`, `iresps='0`, `grant_valid=0`, `grant_idx=0`.
- Issue latency:
  - `ireqs[i].valid` first seen in IDLE at cycle t drives `oreq.valid` at t+1.
  - In HOLD, the owner's valid at h drives `oreq.valid` at h+1.
- Turnaround:
  - Unlocked: `last` at cycle t, IDLE at t+1, next grant on `oreq` at t+2.
  - Locked, with owner valid already high: `last` at t, HOLD at t+1, BUSY at t+2.
- Responses are combinational pass-through in BUSY; no added response latency.
- Reset mid-transaction: outputs clear immediately, and any partial burst is abandoned. The downstream path is reset by the same signal.
- Simultaneous `last` and a new valid from another input: that input is arbitrated in the following IDLE cycle using the updated `ptr`.

## Test plan
- N=2, both valid at cycle 0, ptr=0, single-beat reads:
  - Grant order is 0, 1, 0, 1.
  - `oreq` carries input 0's address at cycle 1, and input 1's at cycle 4 (last at 2, IDLE at 3).
- N=3, only input 2 valid, 4-beat burst:
  - `iresps[2]` shows 4 ready beats; `iresps[0..1]` stay '0 throughout.
  - `ptr=0` afterward.
- Lock chain, LOCK_MAX=4:
  - Input 0 locked issues 6 back-to-back transactions while input 1 waits.
  - Input 0 gets 4, then input 1 gets 1, then input 0 resumes.
- Hold timeout, HOLD_TIMEOUT=16:
  - Input 1 locked finishes, then keeps `ilock` high with no valid; input 0 is waiting.
  - The arbiter leaves HOLD after 16 cycles, and input 0 is granted 2 cycles later.
- Lock drop in HOLD: owner deasserts `ilock` at HOLD cycle 3 -> IDLE next cycle, and `lock_cnt=0`.
- Reset asserted mid-burst (beat 2 of 4):
  - `oreq.valid=0` and `grant_valid=0` in the same cycle.
  - After release, the first request is granted from ptr=0.

Source files
------------

// File: rtl/cbus_rr_arbiter.sv
// Round-robin CBus arbiter: N requesters share one master port,
// with per-owner lock chains bounded in count and idle time.
package cbus_pkg;

  typedef struct packed {
    logic        valid;
    logic        write;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic        err;
    logic [31:0] rdata;
  } cbus_resp_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_HOLD = 2'd2
  } arb_state_t;

endpackage

module cbus_rr_arbiter
  import cbus_pkg::*;
#(
  parameter int NUM_INPUTS   = 2,
  parameter int LOCK_MAX     = 4,
  parameter int HOLD_TIMEOUT = 16,
  localparam int IDXW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  cbus_req_t             ireqs  [NUM_INPUTS],
  input  logic [NUM_INPUTS-1:0] ilock,
  output cbus_resp_t            iresps [NUM_INPUTS],
  output cbus_req_t             oreq,
  input  cbus_resp_t            oresp,
  output logic                  grant_valid,
  output logic [IDXW-1:0]       grant_idx
);

  localparam int LCW = $clog2(LOCK_MAX) + 1;
  localparam int HCW = $clog2(HOLD_TIMEOUT) + 1;

  localparam logic [LCW-1:0]  LOCK_LIM = LCW'(LOCK_MAX - 1);
  localparam logic [HCW-1:0]  HOLD_LIM = HCW'(HOLD_TIMEOUT - 1);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_INPUTS - 1);

  arb_state_t      state, state_n;
  logic [IDXW-1:0] owner, owner_n;
  logic [IDXW-1:0] ptr, ptr_n;
  logic [LCW-1:0]  lock_cnt, lock_n;
  logic [HCW-1:0]  hold_cnt, hold_n;

  logic            found;
  logic [IDXW-1:0] pick;
  logic [IDXW-1:0] cidx;
  int              cand;

  logic            xfer_done;
  logic            owner_valid;
  logic            owner_lock;

  assign xfer_done   = oresp.ready && oresp.last;
  assign owner_valid = ireqs[owner].valid;
  assign owner_lock  = ilock[owner];

  // Scan downward so the candidate closest to ptr wins.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = 0;
    cidx  = '0;
    for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
      cand = int'(ptr) + k;
      if (cand >= NUM_INPUTS) begin
        cand = cand - NUM_INPUTS;
      end
      cidx = IDXW'(cand);
      if (ireqs[cidx].valid) begin
        found = 1'b1;
        pick  = cidx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      owner    <= '0;
      ptr      <= '0;
      lock_cnt <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_n;
      owner    <= owner_n;
      ptr      <= ptr_n;
      lock_cnt <= lock_n;
      hold_cnt <= hold_n;
    end
  end

  always_comb begin
    state_n = state;
    owner_n = owner;
    ptr_n   = ptr;
    lock_n  = lock_cnt;
    hold_n  = hold_cnt;
    unique case (state)
      ST_IDLE: begin
        if (found) begin
          owner_n = pick;
          state_n = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (xfer_done) begin
          ptr_n = (owner == LAST_IDX) ? '0 : owner + 1'b1;
          if (owner_lock && (lock_cnt < LOCK_LIM)) begin
            lock_n  = lock_cnt + 1'b1;
            hold_n  = '0;
            state_n = ST_HOLD;
          end else begin
            lock_n  = '0;
            state_n = ST_IDLE;
          end
        end
      end
      ST_HOLD: begin
        if (owner_valid) begin
          state_n = ST_BUSY;
        end else if (!owner_lock) begin
          lock_n  = '0;
          state_n = ST_IDLE;
        end else if (hold_cnt == HOLD_LIM) begin
          lock_n  = '0;
          state_n = ST_IDLE;
        end else begin
          hold_n = hold_cnt + 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    oreq        = '0;
    grant_valid = 1'b0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      iresps[i] = '0;
    end
    if (state == ST_BUSY) begin
      oreq          = ireqs[owner];
      iresps[owner] = oresp;
      grant_valid   = 1'b1;
    end
  end

  assign grant_idx = owner;

endmodule
